chunked_adder: RTL and testbench

Parametrised multi-cycle ripple adder/subtractor. It replaces the fixed 4-bit combinational full adder wherever wide operands must be added inside a short clock period. The operands are latched on a start pulse. The block then adds CHUNK bits per cycle, LSB chunk first, carrying between chunks in a register. It signals completion with a one-cycle done pulse, alongside carry-out and signed-overflow flags.

---
 rtl/chunked_adder.sv | 107 ++++++++++
 tb/tb_chunked_adder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle ripple adder/subtractor.
// Adds CHUNK bits per cycle, LSB chunk first, carry held in a register.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic [WIDTH-1:0] Y,
  output logic             Co,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH % CHUNK != 0) begin : g_cfg_err
    $error("chunked_adder: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nx;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK:0]   csum;
  logic             last;
  logic             ovf_nx;
  int               base;

  assign base = int'(cnt) * CHUNK;
  assign last = (cnt == LAST);
  assign ca   = a_q[base +: CHUNK];
  assign cb   = b_q[base +: CHUNK];
  assign csum = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, c_q};

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  // Partial sum with the current chunk merged in; final result on last chunk.
  always_comb begin
    sum_nx = sum_q;
    sum_nx[base +: CHUNK] = csum[CHUNK-1:0];
  end

  assign ovf_nx = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (sum_nx[WIDTH-1] != a_q[WIDTH-1]);

  // Control FSM plus operand, carry, partial-sum and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      Y     <= '0;
      Co    <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          sum_q <= sum_nx;
          c_q   <= csum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (last) begin
            Y     <= sum_nx;
            Co    <= csum[CHUNK];
            Ovf   <= ovf_nx;
            cnt   <= '0;
            state <= S_DONE;
          end
        end
        default: begin
          if (start) begin
            a_q   <= A;
            b_q   <= Sub ? ~B : B;
            c_q   <= Ci ^ Sub;
            sum_q <= '0;
            cnt   <= '0;
            state <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: scoreboard bench for chunked_adder.
// Four configurations share operand wires, each with its own start.
module tb_chunked_adder;

  typedef struct packed {
    logic [15:0] y;
    logic        co;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic [3:0]  st = '0;
  logic [15:0] y0, y1, y2;
  logic [7:0]  y3;
  logic [3:0]  co, ovf, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start[4];
  int lat[4] = '{4, 16, 1, 4};
  int ws[4]  = '{16, 16, 16, 8};
  exp_t q[4][$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) d0 (
    .clk(clk), .reset(reset), .start(st[0]), .A(a), .B(b),
    .Ci(ci), .Sub(sub), .Y(y0), .Co(co[0]), .Ovf(ovf[0]),
    .busy(busy[0]), .done(done[0]));

  chunked_adder #(.WIDTH(16), .CHUNK(1)) d1 (
    .clk(clk), .reset(reset), .start(st[1]), .A(a), .B(b),
    .Ci(ci), .Sub(sub), .Y(y1), .Co(co[1]), .Ovf(ovf[1]),
    .busy(busy[1]), .done(done[1]));

  chunked_adder #(.WIDTH(16), .CHUNK(16)) d2 (
    .clk(clk), .reset(reset), .start(st[2]), .A(a), .B(b),
    .Ci(ci), .Sub(sub), .Y(y2), .Co(co[2]), .Ovf(ovf[2]),
    .busy(busy[2]), .done(done[2]));

  chunked_adder #(.WIDTH(8), .CHUNK(2)) d3 (
    .clk(clk), .reset(reset), .start(st[3]), .A(a[7:0]), .B(b[7:0]),
    .Ci(ci), .Sub(sub), .Y(y3), .Co(co[3]), .Ovf(ovf[3]),
    .busy(busy[3]), .done(done[3]));

  function automatic logic [15:0] gy(int k);
    case (k)
      0: gy = y0;
      1: gy = y1;
      2: gy = y2;
      default: gy = {8'h00, y3};
    endcase
  endfunction

  // Reference: plain integer add/subtract with signed range test.
  function automatic exp_t model(int w, logic [15:0] av, logic [15:0] bv,
                                 logic civ, logic subv);
    longint m, ua, ub, sa, sb, c, r, sr;
    exp_t e;
    m  = longint'(1) << w;
    ua = longint'(av) % m;
    ub = longint'(bv) % m;
    c  = longint'(civ);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!subv) begin
      r  = ua + ub + c;
      sr = sa + sb + c;
      e.co = (r >= m);
    end else begin
      r  = ua - ub - c;
      sr = sa - sb - c;
      e.co = (r >= 0);
    end
    if (r < 0) r = r + m;
    e.y   = 16'(r % m);
    e.ovf = (sr < -(m / 2)) || (sr > m / 2 - 1);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: pop expected result whenever a DUT pulses done.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (done[k]) begin
        if (q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done dut%0d: done=1 with nothing pending", k);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("y dut%0d", k), 32'(gy(k)), 32'(e.y));
          chk($sformatf("co dut%0d", k), 32'(co[k]), 32'(e.co));
          chk($sformatf("ovf dut%0d", k), 32'(ovf[k]), 32'(e.ovf));
          chk($sformatf("latency dut%0d", k), cyc - t_start[k], lat[k]);
        end
        chk($sformatf("busy_with_done dut%0d", k), 32'(busy[k]), 0);
      end
    end
  end

  task automatic go(int k, logic [15:0] av, logic [15:0] bv,
                    logic civ, logic subv);
    a = av;
    b = bv;
    ci = civ;
    sub = subv;
    st[k] = 1'b1;
    q[k].push_back(model(ws[k], av, bv, civ, subv));
    @(posedge clk);
    #1;
    t_start[k] = cyc;
    st[k] = 1'b0;
  endtask

  task automatic wait_done(int k, output int dc);
    int n;
    n = 0;
    while (!done[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    dc = cyc;
    if (!done[k]) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: no done within 40 cycles", k);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dc1, dc2, n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset y", 32'(y0), 0);
    chk("reset co", 32'(co[0]), 0);
    chk("reset ovf", 32'(ovf[0]), 0);
    chk("reset busy", 32'(busy[0]), 0);
    chk("reset done", 32'(done[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    go(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_window", 32'(busy[0]), 1);
      chk("y_hold", 32'(y0), 0);
    end
    wait_done(0, dc1);

    go(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(0, dc1);
    go(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(0, dc1);
    go(0, 16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(0, dc1);
    go(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(0, dc1);
    go(0, 16'h0010, 16'h0001, 1'b1, 1'b1);
    wait_done(0, dc1);

    go(0, 16'h0100, 16'h0020, 1'b0, 1'b0);
    a = 16'h1234;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    wait_done(0, dc1);

    a = 16'h1111;
    b = 16'h2222;
    ci = 1'b0;
    sub = 1'b0;
    st[0] = 1'b1;
    q[0].push_back(model(16, 16'h1111, 16'h2222, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    t_start[0] = cyc;
    n = 0;
    while (!done[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    dc1 = cyc;
    if (!done[0]) begin
      checks++;
      errors++;
      $display("FAIL timeout b2b_first: no done within 40 cycles");
    end
    a = 16'hC000;
    b = 16'hC001;
    q[0].push_back(model(16, 16'hC000, 16'hC001, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    t_start[0] = cyc;
    st[0] = 1'b0;
    wait_done(0, dc2);
    chk("b2b_gap", dc2 - dc1, 5);

    void'(model(16, 0, 0, 0, 0));
    go(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q[0].delete();
    @(negedge clk);
    chk("abort busy", 32'(busy[0]), 0);
    chk("abort done", 32'(done[0]), 0);
    chk("abort y", 32'(y0), 0);
    chk("abort co", 32'(co[0]), 0);
    chk("abort ovf", 32'(ovf[0]), 0);
    repeat (6) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done[0]), 0);
    end
    @(posedge clk);
    #1;
    go(0, 16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_done(0, dc1);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 200; i++) begin
        go(k, 16'($urandom), 16'($urandom),
           1'($urandom_range(1)), 1'($urandom_range(1)));
        wait_done(k, dc1);
      end
    end

    repeat (3) @(posedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("pending dut%0d", k), q[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
